serial_match_scheduler: RTL
===========================

# serial_match_scheduler

Shares one serial "101" pattern detector between two word-parallel requesters. A round-robin arbiter grants one requester at a time. The granted word is shifted MSB-first through the detector, which is cleared at the start of every word, and the number of pattern occurrences is reported with a one-cycle DONE strobe. It sits between the parallel front-end producers and the serial detection datapath, and owns all of that datapath's sequencing.

## Interface
- WIDTH, 8: bits per word; legal range 3..15.
- CLOCK  input  1  rising-edge clock for all state.
- RESET  input  1  synchronous, active-high; clears all state on the rising edge of CLOCK where it is high.
- REQA  input  1  requester A has a word pending.
- DATAA  input  WIDTH  word from A; must be held stable while REQA is high and GNTA has not yet been seen.
- REQB  input  1  requester B has a word pending.
- DATAB  input  WIDTH  word from B; same hold rule as DATAA.
- GNTA  output  1  one-cycle pulse: A's word was captured on the previous edge.
- GNTB  output  1  one-cycle pulse: B's word was captured on the previous edge.
- BUSY  output  1  high from the capture edge until DONE drops.
- SER_X  output  1  serial bit currently applied to the detector.
- MATCH  output  1  high during a shift cycle whose bit completes "101".
- DONE  output  1  one-cycle pulse: COUNT and DONE_ID are valid.
- DONE_ID  output  1  0 = result belongs to A, 1 = result belongs to B; holds until the next DONE.
- COUNT  output  4  "101" occurrences in the finished word; holds until the next DONE.

## Operation
- States: IDLE, SHIFT, FIN.
- IDLE
  - Stays here while no request is pending.
  - On an edge with REQA or REQB high, selects a winner and loads its DATA into the shift register.
  - On that same edge: clears the detector to its start state, clears the bit counter and the running count, records the winner in the LAST pointer, and moves to SHIFT.
- Arbitration
  - Only one requester high: it wins.
  - Both requesters high: the one not in LAST wins.
  - Reset value of LAST is B, so A wins the first tie after reset.
- SHIFT
  - SER_X = shift register MSB.
  - Each edge: shift left by one, step the detector with SER_X, increment the bit counter.
  - When MATCH is high, the running count increments on that edge.
  - After the edge that consumes bit WIDTH-1, moves to FIN.
- Detector
  - Overlapping "101" recognizer with states S0 (start), S1 (seen 1), S10 (seen 10).
  - From S0: 1 → S1, 0 → S0.
  - From S1: 1 → S1, 0 → S10.
  - From S10: 1 → S1 with MATCH high, 0 → S0.
  - MATCH is a combinational function of the detector state and SER_X, and is gated to SHIFT only.
  - Because the detector is cleared at every capture, no match can span two words.
- FIN
  - DONE = 1; COUNT and DONE_ID load from the running count and LAST.
  - Next state is always IDLE.
  - A request pending during FIN is not captured until the following IDLE edge.
- Count width: the maximum count is floor((WIDTH-1)/2), which is at most 7 for the legal WIDTH range, so COUNT cannot overflow.
- Reset values: GNTA = GNTB = BUSY = SER_X = MATCH = DONE = DONE_ID = 0; COUNT = 0; state = IDLE; LAST = B; shift register, bit counter and detector cleared.

## Timing
- Capture edge E0 (in IDLE) starts the sequence. Cycles below are counted after E0.
- Cycle 0: GNTx = 1, BUSY = 1, SER_X = bit WIDTH-1 (the MSB).
- Cycles 0 through WIDTH-1: one bit per cycle, MSB first.
- Cycle WIDTH: DONE = 1, COUNT valid, BUSY still 1.
- Cycle WIDTH+1: IDLE, BUSY = 0; the earliest next capture is the edge at the end of this cycle.
- Back-to-back throughput: one word per WIDTH+2 cycles.
- Requesters sample GNTx at the end of cycle 0 and must drop REQ or change DATA by cycle 1. A REQ still high in IDLE is treated as a new word.
- RESET during SHIFT or FIN aborts the word: no DONE, COUNT returns to 0, LAST returns to B.
- RESET has priority over every other event on the same edge.

## Test plan
- Single word: reset, then REQA with DATAA = 8'hAA → GNTA in cycle 0; SER_X = 1,0,1,0,1,0,1,0; MATCH in cycles 2, 4, 6; DONE in cycle 8 with COUNT = 3, DONE_ID = 0.
- Tie after reset: REQA (8'h05) and REQB (8'hFF) raised together → A is served first (COUNT = 1, ID 0); B's GNTB pulses 10 cycles after GNTA (COUNT = 0, ID 1).
- Fairness: REQA and REQB held high continuously → grants alternate A, B, A, B, with GNT pulses spaced 10 cycles apart and no starvation.
- Overlap and isolation:
  - 8'hB5 → COUNT = 3, with MATCH in cycles 2, 5, 7.
  - 8'h02 then 8'h80 back-to-back → COUNT = 0 for both; a "1 0 | 1" pattern across the word boundary must not match.
- Reset mid-word: assert RESET for one cycle during cycle 4 of a SHIFT → no DONE; all outputs 0 on the next cycle; a following simultaneous REQA/REQB is granted to A.

Source files
------------

// File: rtl/serial_match_scheduler.sv
// Round-robin scheduler sharing one serial "101" detector between two word-parallel requesters.
// Each granted word is shifted MSB-first through a freshly cleared detector and its match count reported.
module serial_match_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             REQA,
  input  logic [WIDTH-1:0] DATAA,
  input  logic             REQB,
  input  logic [WIDTH-1:0] DATAB,
  output logic             GNTA,
  output logic             GNTB,
  output logic             BUSY,
  output logic             SER_X,
  output logic             MATCH,
  output logic             DONE,
  output logic             DONE_ID,
  output logic [3:0]       COUNT
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
  typedef enum logic [1:0] {S0, S1, S10} det_t;

  state_t           state_reg, state_next;
  det_t             det_reg, det_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [CW-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [3:0]       run_cnt_reg, run_cnt_next;
  logic [3:0]       count_reg, count_next;
  logic             last_reg, last_next;       // 0 = A served last, 1 = B served last
  logic             done_id_reg, done_id_next;
  logic [1:0]       gnt_reg, gnt_next;         // bit 0 = A, bit 1 = B
  logic             winner;
  logic             ser_x;
  logic             match;

  // On a tie the requester not served last wins; otherwise the sole requester wins.
  always_comb begin
    if (REQA && REQB) winner = ~last_reg;
    else              winner = REQB;
  end

  always_comb begin
    state_next   = state_reg;
    det_next     = det_reg;
    shreg_next   = shreg_reg;
    bit_cnt_next = bit_cnt_reg;
    run_cnt_next = run_cnt_reg;
    count_next   = count_reg;
    last_next    = last_reg;
    done_id_next = done_id_reg;
    gnt_next     = 2'b00;
    ser_x        = 1'b0;
    match        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (REQA || REQB) begin
          shreg_next   = winner ? DATAB : DATAA;
          det_next     = S0;
          bit_cnt_next = '0;
          run_cnt_next = 4'd0;
          last_next    = winner;
          gnt_next     = winner ? 2'b10 : 2'b01;
          state_next   = SHIFT;
        end
      end

      SHIFT: begin
        ser_x = shreg_reg[WIDTH-1];
        case (det_reg)
          S0:  det_next = ser_x ? S1 : S0;
          S1:  det_next = ser_x ? S1 : S10;
          S10: begin
            det_next = ser_x ? S1 : S0;
            match    = ser_x;
          end
          default: det_next = S0;
        endcase
        shreg_next   = {shreg_reg[WIDTH-2:0], 1'b0};
        bit_cnt_next = bit_cnt_reg + CW'(1);
        if (match) run_cnt_next = run_cnt_reg + 4'd1;
        // Result registers load on the edge into FIN so they are valid alongside DONE.
        if (bit_cnt_reg == CW'(WIDTH-1)) begin
          state_next   = FIN;
          count_next   = run_cnt_next;
          done_id_next = last_reg;
        end
      end

      FIN: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_reg   <= IDLE;
      det_reg     <= S0;
      shreg_reg   <= '0;
      bit_cnt_reg <= '0;
      run_cnt_reg <= 4'd0;
      count_reg   <= 4'd0;
      last_reg    <= 1'b1;
      done_id_reg <= 1'b0;
      gnt_reg     <= 2'b00;
    end else begin
      state_reg   <= state_next;
      det_reg     <= det_next;
      shreg_reg   <= shreg_next;
      bit_cnt_reg <= bit_cnt_next;
      run_cnt_reg <= run_cnt_next;
      count_reg   <= count_next;
      last_reg    <= last_next;
      done_id_reg <= done_id_next;
      gnt_reg     <= gnt_next;
    end
  end

  assign GNTA    = gnt_reg[0];
  assign GNTB    = gnt_reg[1];
  assign BUSY    = (state_reg != IDLE);
  assign SER_X   = ser_x;
  assign MATCH   = match;
  assign DONE    = (state_reg == FIN);
  assign DONE_ID = done_id_reg;
  assign COUNT   = count_reg;

endmodule
